// File: rtl/cmd_router_pkg.sv
// cmd_router_pkg: shared types and constants for the command router.
//   state_t  - router FSM states
//   ERR_*    - cmd_err response status codes
//   DW_DEF   - default command field width
package cmd_router_pkg;

  localparam int unsigned DW_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_TMO = 2'b01;
  localparam logic [1:0] ERR_DEV = 2'b10;

endpackage

// File: rtl/cmd_router_tmo.sv
// cmd_router_tmo: response timeout counter.
//   clk_sys - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   clr     - synchronous clear (held while the command is issued)
//   en      - count enable (one increment per waiting cycle)
//   expire  - high in the enabled cycle where the count has reached TO_CYC-1
module cmd_router_tmo #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned     CW    = $clog2(TO_CYC);
  localparam logic [CW-1:0]   LIMIT = CW'(TO_CYC - 1);

  logic [CW-1:0] cnt;

  always_comb begin
    expire = en && (cnt == LIMIT);
  end

  // Saturates at the limit so an unexpected extra enable cannot wrap.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !expire) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_router.sv
// cmd_router: routes one command at a time to a local target or one of NR
// remote channels and returns a single response with status.
//   clk_sys, rst_n                 - clock, asynchronous active-low reset
//   cmd_dev/mod/addr/data/vld/rdy  - upstream command (0 = local, 1..NR remote)
//   cmd_q/qvld/err                 - upstream response (one-cycle strobe)
//   cmdr_mod/addr/data, cmdr_vld   - shared remote bus, one-hot issue strobe
//   cmdr_q, cmdr_qvld              - remote responses, channel i at [i*DW +: DW]
//   cmdl_mod/addr/data, cmdl_vld   - local command bus and issue strobe
//   cmdl_q, cmdl_qvld              - local response
module cmd_router
  import cmd_router_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned NR     = 4,
  parameter int unsigned TO_CYC = 255
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic [7:0]         cmd_dev,
  input  logic [DW-1:0]      cmd_mod,
  input  logic [DW-1:0]      cmd_addr,
  input  logic [DW-1:0]      cmd_data,
  input  logic               cmd_vld,
  output logic               cmd_rdy,
  output logic [DW-1:0]      cmd_q,
  output logic               cmd_qvld,
  output logic [1:0]         cmd_err,
  output logic [DW-1:0]      cmdr_mod,
  output logic [DW-1:0]      cmdr_addr,
  output logic [DW-1:0]      cmdr_data,
  output logic [NR-1:0]      cmdr_vld,
  input  logic [NR*DW-1:0]   cmdr_q,
  input  logic [NR-1:0]      cmdr_qvld,
  output logic [DW-1:0]      cmdl_mod,
  output logic [DW-1:0]      cmdl_addr,
  output logic [DW-1:0]      cmdl_data,
  output logic               cmdl_vld,
  input  logic [DW-1:0]      cmdl_q,
  input  logic               cmdl_qvld
);

  state_t          state, state_nxt;
  logic [7:0]      dev_r;
  logic [DW-1:0]   mod_r, addr_r, data_r;
  logic            resp_vld;
  logic [DW-1:0]   resp_q;
  logic [1:0]      resp_err;

  logic            accept;
  logic            dev_bad_in;
  logic            is_local, is_remote;
  logic            tgt_qvld;
  logic [DW-1:0]   tgt_q;
  logic            expire;

  cmd_router_tmo #(.TO_CYC(TO_CYC)) u_tmo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .clr     (state == ST_ISSUE),
    .en      (state == ST_WAIT),
    .expire  (expire)
  );

  always_comb begin
    accept     = cmd_vld && (state == ST_IDLE);
    dev_bad_in = 32'(cmd_dev) > NR;
    is_local   = (dev_r == '0);
    is_remote  = (dev_r != '0) && (32'(dev_r) <= NR);
  end

  // Only the latched target's strobe/data are visible to the FSM.
  always_comb begin
    tgt_qvld = 1'b0;
    tgt_q    = '0;
    if (is_local) begin
      tgt_qvld = cmdl_qvld;
      tgt_q    = cmdl_q;
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (dev_r == 8'(i + 1)) begin
        tgt_qvld = cmdr_qvld[i];
        tgt_q    = cmdr_q[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_vld) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = (is_local || is_remote) ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (tgt_qvld || expire) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      dev_r  <= '0;
      mod_r  <= '0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dev_r  <= cmd_dev;
        mod_r  <= cmd_mod;
        addr_r <= cmd_addr;
        data_r <= cmd_data;
      end
    end
  end

  // Response register defaults to zero each cycle, giving a one-cycle strobe
  // with q/err forced to 0 otherwise. A bad device is flagged at acceptance
  // so the error strobe lands in the ISSUE cycle.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld <= 1'b0;
      resp_q   <= '0;
      resp_err <= ERR_OK;
    end else begin
      resp_vld <= 1'b0;
      resp_q   <= '0;
      resp_err <= ERR_OK;
      if (accept && dev_bad_in) begin
        resp_vld <= 1'b1;
        resp_err <= ERR_DEV;
      end else if (state == ST_WAIT) begin
        if (tgt_qvld) begin
          resp_vld <= 1'b1;
          resp_q   <= tgt_q;
        end else if (expire) begin
          resp_vld <= 1'b1;
          resp_err <= ERR_TMO;
        end
      end
    end
  end

  always_comb begin
    cmd_rdy   = (state == ST_IDLE);
    cmd_qvld  = resp_vld;
    cmd_q     = resp_q;
    cmd_err   = resp_err;
    cmdl_vld  = (state == ST_ISSUE) && is_local;
    cmdl_mod  = is_local  ? mod_r  : '0;
    cmdl_addr = is_local  ? addr_r : '0;
    cmdl_data = is_local  ? data_r : '0;
    cmdr_mod  = is_remote ? mod_r  : '0;
    cmdr_addr = is_remote ? addr_r : '0;
    cmdr_data = is_remote ? data_r : '0;
    cmdr_vld  = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      cmdr_vld[i] = (state == ST_ISSUE) && (dev_r == 8'(i + 1));
    end
  end

endmodule

// File: tb/tb_cmd_router.sv
// tb_cmd_router: directed bench for cmd_router (DW=8, NR=4, TO_CYC=8) with a
// response scoreboard checked on the falling clock edge.
module tb_cmd_router;
  import cmd_router_pkg::*;

  localparam int unsigned DW     = 8;
  localparam int unsigned NR     = 4;
  localparam int unsigned TO_CYC = 8;

  logic              clk_sys = 1'b0;
  logic              rst_n   = 1'b0;
  logic [7:0]        cmd_dev;
  logic [DW-1:0]     cmd_mod, cmd_addr, cmd_data;
  logic              cmd_vld;
  logic              cmd_rdy;
  logic [DW-1:0]     cmd_q;
  logic              cmd_qvld;
  logic [1:0]        cmd_err;
  logic [DW-1:0]     cmdr_mod, cmdr_addr, cmdr_data;
  logic [NR-1:0]     cmdr_vld;
  logic [NR*DW-1:0]  cmdr_q;
  logic [NR-1:0]     cmdr_qvld;
  logic [DW-1:0]     cmdl_mod, cmdl_addr, cmdl_data;
  logic              cmdl_vld;
  logic [DW-1:0]     cmdl_q;
  logic              cmdl_qvld;

  always #5 clk_sys = ~clk_sys;

  cmd_router #(.DW(DW), .NR(NR), .TO_CYC(TO_CYC)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .cmd_dev   (cmd_dev),
    .cmd_mod   (cmd_mod),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .cmd_vld   (cmd_vld),
    .cmd_rdy   (cmd_rdy),
    .cmd_q     (cmd_q),
    .cmd_qvld  (cmd_qvld),
    .cmd_err   (cmd_err),
    .cmdr_mod  (cmdr_mod),
    .cmdr_addr (cmdr_addr),
    .cmdr_data (cmdr_data),
    .cmdr_vld  (cmdr_vld),
    .cmdr_q    (cmdr_q),
    .cmdr_qvld (cmdr_qvld),
    .cmdl_mod  (cmdl_mod),
    .cmdl_addr (cmdl_addr),
    .cmdl_data (cmdl_data),
    .cmdl_vld  (cmdl_vld),
    .cmdl_q    (cmdl_q),
    .cmdl_qvld (cmdl_qvld)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [DW-1:0] q;
    logic [1:0]    err;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_resp(input logic [DW-1:0] q, input logic [1:0] err);
    exp_t e;
    e.q   = q;
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Presents a command once the router is ready; returns in the ISSUE cycle.
  task automatic send(input logic [7:0] dev, input logic [DW-1:0] mod,
                      input logic [DW-1:0] addr, input logic [DW-1:0] data);
    int unsigned n = 0;
    while (!cmd_rdy && n < 50) begin
      tick();
      n++;
    end
    check("send_rdy", cmd_rdy, 1);
    cmd_dev  = dev;
    cmd_mod  = mod;
    cmd_addr = addr;
    cmd_data = data;
    cmd_vld  = 1'b1;
    tick();
    cmd_vld  = 1'b0;
  endtask

  always @(negedge clk_sys) begin : mon
    exp_t e;
    if (rst_n) begin
      if (cmd_qvld) begin
        if (sb.size() == 0) begin
          check("sb_extra", cmd_qvld, 0);
        end else begin
          e = sb.pop_front();
          check("sb_q", cmd_q, e.q);
          check("sb_err", cmd_err, e.err);
        end
      end else begin
        check("sb_idle_zero", {cmd_err, cmd_q}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cmd_dev = '0; cmd_mod = '0; cmd_addr = '0; cmd_data = '0; cmd_vld = 1'b0;
    cmdr_q = '0; cmdr_qvld = '0; cmdl_q = '0; cmdl_qvld = 1'b0;

    // Reset state
    #1;
    check("rst_rdy", cmd_rdy, 1);
    check("rst_qvld", cmd_qvld, 0);
    check("rst_lvld", cmdl_vld, 0);
    check("rst_rvld", cmdr_vld, 0);
    check("rst_raddr", cmdr_addr, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("rdy_after_rst", cmd_rdy, 1);

    // Local target, response three cycles after issue
    send(8'd0, 8'h11, 8'h12, 8'h33);
    check("loc_vld", cmdl_vld, 1);
    check("loc_rvld", cmdr_vld, 0);
    check("loc_addr", cmdl_addr, 8'h12);
    check("loc_mod", cmdl_mod, 8'h11);
    check("loc_rbus_zero", cmdr_addr, 0);
    check("loc_busy", cmd_rdy, 0);
    tick();
    check("loc_vld_once", cmdl_vld, 0);
    check("loc_hold", cmdl_data, 8'h33);
    tick();
    tick();
    cmdl_q = 8'hA5; cmdl_qvld = 1'b1;
    expect_resp(8'hA5, ERR_OK);
    tick();
    cmdl_qvld = 1'b0; cmdl_q = '0;
    check("loc_qvld", cmd_qvld, 1);
    check("loc_q", cmd_q, 8'hA5);
    check("loc_resp_busy", cmd_rdy, 0);
    tick();
    check("loc_idle", cmd_rdy, 1);
    check("loc_qvld_once", cmd_qvld, 0);
    check("loc_bus_held", cmdl_addr, 8'h12);

    // Remote channel 2, non-selected strobes ignored
    send(8'd3, 8'h21, 8'h22, 8'h23);
    check("rem_vld", cmdr_vld, 4'b0100);
    check("rem_lvld", cmdl_vld, 0);
    check("rem_addr", cmdr_addr, 8'h22);
    check("rem_lbus_zero", cmdl_addr, 0);
    tick();
    check("rem_vld_once", cmdr_vld, 0);
    cmdr_q[0*DW +: DW] = 8'h77; cmdr_qvld = 4'b0001;
    cmdl_q = 8'h66; cmdl_qvld = 1'b1;
    tick();
    cmdr_qvld = '0; cmdl_qvld = 1'b0;
    check("rem_ignore", cmd_qvld, 0);
    check("rem_still_busy", cmd_rdy, 0);
    cmdr_q[2*DW +: DW] = 8'h5A; cmdr_q[0*DW +: DW] = 8'hFF;
    cmdr_qvld = 4'b0101;
    expect_resp(8'h5A, ERR_OK);
    tick();
    cmdr_qvld = '0;
    check("rem_qvld", cmd_qvld, 1);
    check("rem_q", cmd_q, 8'h5A);
    check("rem_err", cmd_err, ERR_OK);
    tick();
    check("rem_idle", cmd_rdy, 1);

    // Bad device 7, then boundary NR+1
    expect_resp('0, ERR_DEV);
    send(8'd7, 8'h31, 8'h32, 8'h34);
    check("bad_qvld", cmd_qvld, 1);
    check("bad_err", cmd_err, ERR_DEV);
    check("bad_q", cmd_q, 0);
    check("bad_lvld", cmdl_vld, 0);
    check("bad_rvld", cmdr_vld, 0);
    check("bad_rbus", cmdr_addr, 0);
    check("bad_lbus", cmdl_addr, 0);
    tick();
    check("bad_resp_busy", cmd_rdy, 0);
    check("bad_qvld_once", cmd_qvld, 0);
    tick();
    check("bad_idle", cmd_rdy, 1);
    expect_resp('0, ERR_DEV);
    send(8'd5, 8'h01, 8'h02, 8'h03);
    check("bad5_err", cmd_err, ERR_DEV);
    check("bad5_rvld", cmdr_vld, 0);
    tick();
    tick();

    // Timeout on channel 3 (dev = NR), late response dropped
    send(8'd4, 8'h41, 8'h42, 8'h43);
    check("tmo_rvld", cmdr_vld, 4'b1000);
    expect_resp('0, ERR_TMO);
    for (int k = 1; k <= 8; k++) begin
      tick();
      check("tmo_wait", cmd_qvld, 0);
    end
    tick();
    check("tmo_qvld", cmd_qvld, 1);
    check("tmo_err", cmd_err, ERR_TMO);
    check("tmo_q", cmd_q, 0);
    tick();
    check("tmo_idle", cmd_rdy, 1);
    tick();
    cmdr_q[3*DW +: DW] = 8'hEE; cmdr_qvld = 4'b1000;
    tick();
    cmdr_qvld = '0;
    check("late_drop", cmd_qvld, 0);
    tick();
    check("late_drop2", cmd_qvld, 0);

    // Busy hold and response on the timeout-limit cycle
    send(8'd0, 8'h51, 8'h52, 8'h53);
    tick();
    cmd_dev = 8'd0; cmd_mod = 8'h61; cmd_addr = 8'h62; cmd_data = 8'h63;
    cmd_vld = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      check("race_busy", cmd_rdy, 0);
      check("race_novld", cmdl_vld, 0);
      check("race_bus_hold", cmdl_addr, 8'h52);
    end
    cmdl_q = 8'hC3; cmdl_qvld = 1'b1;
    expect_resp(8'hC3, ERR_OK);
    tick();
    cmdl_qvld = 1'b0;
    check("race_qvld", cmd_qvld, 1);
    check("race_err", cmd_err, ERR_OK);
    check("race_q", cmd_q, 8'hC3);
    check("race_resp_busy", cmd_rdy, 0);
    tick();
    check("race_idle", cmd_rdy, 1);
    tick();
    cmd_vld = 1'b0;
    check("held_vld", cmdl_vld, 1);
    check("held_addr", cmdl_addr, 8'h62);
    tick();
    cmdl_q = 8'h3C; cmdl_qvld = 1'b1;
    expect_resp(8'h3C, ERR_OK);
    tick();
    cmdl_qvld = 1'b0;
    check("held_q", cmd_q, 8'h3C);
    tick();

    // Reset during WAIT abandons the command
    send(8'd1, 8'h71, 8'h72, 8'h73);
    check("rst_op_rvld", cmdr_vld, 4'b0001);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_op_rdy", cmd_rdy, 1);
    check("rst_op_bus", cmdr_addr, 0);
    check("rst_op_rvld0", cmdr_vld, 0);
    check("rst_op_qvld", cmd_qvld, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    cmdr_q[0*DW +: DW] = 8'h99; cmdr_qvld = 4'b0001;
    tick();
    cmdr_qvld = '0;
    check("rst_op_noq", cmd_qvld, 0);
    check("rst_op_rdy2", cmd_rdy, 1);
    tick();
    check("rst_op_noq2", cmd_qvld, 0);
    tick();

    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
